pool_cmp_lanes: RTL and testbench
=================================

Name: pool_cmp_lanes

Overview:
- Parametrised multi-lane FP16 max/min pooling unit.
- Reduces a programmable-length window of FP16 elements per lane into one result per lane.
- Sits between the pooling data fetch and the result writeback, in the same position as the single-lane max-pooling comparator.
- Uses a native in-fabric FP16 ordered compare (no comparator IP) and has explicit window framing, min mode, and valid/ready backpressure on both sides.

Parameters:
- LANES, 4, number of independent channels processed in parallel.
- DW, 16, element width; FP16 only, must stay 16.
- CNT_W, 8, width of window-length counter (max window 2^CNT_W-1 elements).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches mode and win_len, opens a window. Honoured only in IDLE, or in DONE on the cycle of the output handshake.
- mode  in  1  0 = max pooling, 1 = min pooling; sampled on start.
- win_len  in  CNT_W  elements per window; sampled on start; 0 treated as 1.
- in_data  in  LANES*DW  lane i at bits [i*DW +: DW].
- in_valid  in  1  producer has in_data.
- in_ready  out  1  unit accepts a beat this cycle.
- out_data  out  LANES*DW  pooled result per lane.
- out_valid  out  1  out_data holds a completed window.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in ACC or DONE.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; out_data=0, out_valid=0, in_ready=0, busy=0; counter and latched mode/len cleared. Reset mid-window discards all partial results, with no output.
- States and transitions:
  - IDLE: in_ready=0. start -> ACC, count=0.
  - ACC: in_ready=1. Each beat (in_valid & in_ready) updates all lanes together:
    - count==0: acc = in_data (no carry-over from the previous window).
    - otherwise: acc = select(acc, in_data) per lane.
    - count increments.
    - The beat with count == len-1 moves to DONE.
  - DONE: in_ready=0, out_valid=1, out_data=acc.
    - Handshake (out_valid & out_ready) -> IDLE.
    - If start is high on the handshake cycle, go directly to ACC with the new mode/len.
- Latency: out_valid rises on the cycle after the last beat is accepted. Back-to-back windows give one dead input cycle per window, or two if start is not overlapped with the handshake.
- out_data and out_valid hold stable while out_valid & !out_ready.
- start is ignored in ACC and in DONE without a handshake. in_valid is ignored outside ACC.
- FP16 select(acc, d), per lane, with ties keeping acc:
  - NaN (exp=1F, mant!=0): a NaN d never replaces acc. A NaN acc is replaced by any non-NaN d. Both NaN: keep acc.
  - +0 and -0 compare equal.
  - Ordering key: sign=0 -> {1, mag}; sign=1 -> {0, ~mag}, where mag is 15 bits. Compare keys unsigned, after forcing both zeros to the same key.
  - max mode: take d if key(d) > key(acc). min mode: take d if key(d) < key(acc).
  - Infinities order naturally.
- Single-element window (win_len 0 or 1): out_data = that element, unchanged, including NaN or -0.
- The compare is combinational into the acc register; there are no multicycle paths.

Test Plan:
- Max, win_len=3, lane0 beats 3C00, 4000, BC00 (1, 2, -1) -> out_valid one cycle after beat 3; lane0 out=4000.
- Min, win_len=4, lane1 beats C000, BC00, 7C00, 0000 -> lane1 out=C000 (-2). All LANES lanes checked independently with distinct streams.
- NaN and zero: max, beats 7E00, 8000, 0000 -> out=8000 (NaN skipped; +0 ties keep -0). Window of all 7E00 -> out=7E00.
- Backpressure: out_ready low for 5 cycles -> out_data/out_valid stable, in_ready=0. in_valid gaps mid-window -> same result as without gaps.
- Back-to-back: start on the handshake cycle with win_len=0 -> next beat accepted next cycle, passed through unchanged. start during ACC ignored.
- Reset: assert rst=0 after 2 of 4 beats -> all outputs 0. New window 3C00, 3C00 -> out=3C00, no residue from before reset.

Source files
------------

// File: rtl/pool_cmp_lanes_if.sv
// rtl/pool_cmp_lanes_if.sv - handshake/bus bundle for the multi-lane FP16 pooling unit
//
// Groups the window framing, input stream and output stream of pool_cmp_lanes.
//   start/mode/win_len : window open pulse plus the mode and length it latches
//   in_data/in_valid/in_ready    : input beats, LANES FP16 elements per beat
//   out_data/out_valid/out_ready : pooled result, one FP16 per lane
//   busy                         : unit is accumulating or holding a result
// master = producer/consumer side, slave = pooling unit.
interface pool_cmp_lanes_if #(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int CNT_W = 8
) ();
   logic                  start;
   logic                  mode;
   logic [CNT_W-1:0]      win_len;
   logic [LANES*DW-1:0]   in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;

   modport master (
      output start, mode, win_len, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, busy
   );

   modport slave (
      input  start, mode, win_len, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, busy
   );
endinterface

// File: rtl/pool_cmp_lanes.sv
// rtl/pool_cmp_lanes.sv - multi-lane FP16 max/min window pooling unit
//
// Reduces a window of win_len beats (0 means 1) into one FP16 result per lane.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : pool_cmp_lanes_if.slave (start/mode/win_len, in_* stream, out_* stream, busy)
// Lane i of in_data/out_data sits at bits [i*DW +: DW]. DW must be 16.
module pool_cmp_lanes #(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   pool_cmp_lanes_if.slave       bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    len_r;
   logic                mode_r;
   logic [LANES*DW-1:0] acc;
   logic [LANES*DW-1:0] acc_nxt;
   logic                start_ok;
   logic                beat;
   logic                last_beat;
   logic [CNT_W-1:0]    len_eff;

   function automatic logic is_nan(input logic [DW-1:0] x);
      return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
   endfunction

   // Monotonic unsigned key: positives above negatives, negative magnitudes
   // inverted so larger magnitude sorts lower. Both zeros share the +0 key.
   function automatic logic [DW-1:0] ord_key(input logic [DW-1:0] x);
      if (x[14:0] == 15'd0)
         return 16'h8000;
      else if (!x[15])
         return {1'b1, x[14:0]};
      else
         return {1'b0, ~x[14:0]};
   endfunction

   // Ties keep acc; a NaN candidate never wins; a NaN acc loses to any number.
   function automatic logic take_d(input logic mn, input logic [DW-1:0] a,
                                   input logic [DW-1:0] d);
      logic [DW-1:0] ka;
      logic [DW-1:0] kd;
      ka = ord_key(a);
      kd = ord_key(d);
      if (is_nan(d))
         return 1'b0;
      else if (is_nan(a))
         return 1'b1;
      else if (mn)
         return kd < ka;
      else
         return kd > ka;
   endfunction

   assign len_eff   = (bus.win_len == '0) ? ONE : bus.win_len;
   assign bus.in_ready  = (state == S_ACC);
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_data  = acc;
   assign beat      = bus.in_valid && (state == S_ACC);
   assign last_beat = (count == (len_r - ONE));

   // First beat of a window loads straight in so nothing carries over.
   always_comb begin
      acc_nxt = acc;
      for (int i = 0; i < LANES; i++) begin
         if (count == '0)
            acc_nxt[i*DW +: DW] = bus.in_data[i*DW +: DW];
         else if (take_d(mode_r, acc[i*DW +: DW], bus.in_data[i*DW +: DW]))
            acc_nxt[i*DW +: DW] = bus.in_data[i*DW +: DW];
      end
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt = S_ACC;
               start_ok  = 1'b1;
            end
         end
         S_ACC: begin
            if (beat && last_beat)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               if (bus.start) begin
                  state_nxt = S_ACC;
                  start_ok  = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         count  <= '0;
         len_r  <= '0;
         mode_r <= 1'b0;
         acc    <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            mode_r <= bus.mode;
            len_r  <= len_eff;
            count  <= '0;
         end else if (beat) begin
            count <= count + ONE;
         end
         if (beat)
            acc <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_pool_cmp_lanes.sv
// tb/tb_pool_cmp_lanes.sv - self-checking bench for pool_cmp_lanes
module tb_pool_cmp_lanes;
   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int CNT_W = 8;
   localparam int BW    = LANES * DW;

   logic clk;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   pool_cmp_lanes_if #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) bus ();

   pool_cmp_lanes #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                  16'h7E00, 16'hFE01, 16'h3C00, 16'hBC00};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit fp_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
   endfunction

   // Exact value scaled by 2^24 as a signed integer; infinity is a huge number.
   function automatic longint fp_val(input logic [15:0] x);
      longint mg;
      int e;
      e = int'(x[14:10]);
      if (e == 0)
         mg = longint'(x[9:0]);
      else if (e == 31)
         mg = longint'(1) << 50;
      else
         mg = longint'(1024 + int'(x[9:0])) << (e - 1);
      return x[15] ? -mg : mg;
   endfunction

   function automatic logic [BW-1:0] pool_ref(input bit md, input logic [BW-1:0] q[$]);
      logic [BW-1:0] r;
      logic [15:0]   a;
      logic [15:0]   d;
      for (int ln = 0; ln < LANES; ln++) begin
         a = q[0][ln*DW +: DW];
         for (int k = 1; k < q.size(); k++) begin
            d = q[k][ln*DW +: DW];
            if (fp_nan(d)) continue;
            if (fp_nan(a)) a = d;
            else if (md ? (fp_val(d) < fp_val(a)) : (fp_val(d) > fp_val(a))) a = d;
         end
         r[ln*DW +: DW] = a;
      end
      return r;
   endfunction

   // Model state: which phase the window is in, and the beats seen so far.
   bit            m_acc  = 1'b0;
   bit            m_done = 1'b0;
   bit            m_zero = 1'b1;
   bit            m_mode = 1'b0;
   int            m_len  = 1;
   logic [BW-1:0] m_exp  = '0;
   logic [BW-1:0] m_beats[$];

   always @(negedge clk) begin
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_done});
      chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, m_acc});
      chk("busy",      {63'd0, bus.busy},      {63'd0, m_acc | m_done});
      if (m_done) chk("out_data", bus.out_data, m_exp);
      if (m_zero) chk("out_data_reset", bus.out_data, 64'd0);

      if (!rst) begin
         m_acc = 0; m_done = 0; m_zero = 1;
         m_beats.delete();
      end else if (m_acc) begin
         if (bus.in_valid) begin
            m_beats.push_back(bus.in_data);
            m_zero = 0;
            if (m_beats.size() == m_len) begin
               m_exp  = pool_ref(m_mode, m_beats);
               m_acc  = 0;
               m_done = 1;
            end
         end
      end else if (m_done) begin
         if (bus.out_ready) begin
            m_done = 0;
            if (bus.start) begin
               m_acc = 1; m_mode = bus.mode;
               m_len = (bus.win_len == 0) ? 1 : int'(bus.win_len);
               m_beats.delete();
            end
         end
      end else if (bus.start) begin
         m_acc = 1; m_mode = bus.mode;
         m_len = (bus.win_len == 0) ? 1 : int'(bus.win_len);
         m_beats.delete();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rfp();
      int idx;
      if ($urandom_range(0, 3) == 0) begin
         idx = $urandom_range(0, 7);
         return specials[idx];
      end
      return 16'($urandom);
   endfunction

   function automatic logic [BW-1:0] mk(input logic [15:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic open_win(input bit md, input int wl);
      bus.start = 1'b1; bus.mode = md; bus.win_len = CNT_W'(wl);
      tick();
      bus.start = 1'b0; bus.mode = 1'($urandom); bus.win_len = CNT_W'($urandom);
   endtask

   task automatic send(input logic [BW-1:0] bt[$], input int gap_pct, input bit poke_start);
      bit ok;
      int t;
      for (int k = 0; k < bt.size(); k++) begin
         for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
            bus.in_valid = 1'b0; bus.in_data = {$urandom, $urandom};
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = bt[k];
         if (poke_start && k == 1) begin
            bus.start = 1'b1; bus.mode = ~bus.mode; bus.win_len = 8'd1;
         end
         t = 0;
         do begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            bus.start = 1'b0;
            t++;
         end while (!ok && t < 50);
         chk("beat_accept", {63'd0, ok}, 64'd1);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int t = 0;
      while (!bus.out_valid && t < 50) begin
         tick();
         t++;
      end
      chk("out_valid_wait", {63'd0, bus.out_valid}, 64'd1);
   endtask

   task automatic release_out(input int stall, input bit chain, input bit md, input int wl);
      for (int s = 0; s < stall; s++) begin
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'($urandom);
         bus.in_data   = {$urandom, $urandom};
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (chain) begin
         bus.start = 1'b1; bus.mode = md; bus.win_len = CNT_W'(wl);
      end
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
   endtask

   task automatic lane_is(input int ln, input logic [15:0] e, input string nm);
      chk(nm, {48'd0, bus.out_data[ln*DW +: DW]}, {48'd0, e});
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [BW-1:0] bt[$];
      bit  chained;
      bit  md;
      bit  nmd;
      bit  chain;
      int  wl;
      int  nwl;
      int  eff;

      rst = 1'b0;
      bus.start = 0; bus.mode = 0; bus.win_len = '0;
      bus.in_data = '0; bus.in_valid = 0; bus.out_ready = 0;
      tick(); tick();
      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_out_data", bus.out_data, 64'd0);
      rst = 1'b1;
      tick();

      // Max, length 3
      open_win(0, 3);
      bt = '{mk(16'h3C00, 16'h1111, 16'h2222, 16'h3333),
             mk(16'h4000, 16'h1112, 16'h2221, 16'hB333),
             mk(16'hBC00, 16'h0001, 16'h2223, 16'h3334)};
      send(bt, 0, 0);
      chk("max3_valid_next_cycle", {63'd0, bus.out_valid}, 64'd1);
      lane_is(0, 16'h4000, "max3_lane0");
      lane_is(3, 16'h3334, "max3_lane3");
      release_out(0, 0, 0, 0);

      // Min, length 4, distinct streams per lane
      open_win(1, 4);
      bt = '{mk(16'h7E00, 16'hC000, 16'h3C00, 16'hFC00),
             mk(16'h4500, 16'hBC00, 16'h3800, 16'h7C00),
             mk(16'h4500, 16'h7C00, 16'h3400, 16'h0001),
             mk(16'hC500, 16'h0000, 16'h3000, 16'h8001)};
      send(bt, 0, 0);
      wait_out();
      lane_is(0, 16'hC500, "min4_lane0");
      lane_is(1, 16'hC000, "min4_lane1");
      lane_is(2, 16'h3000, "min4_lane2");
      lane_is(3, 16'hFC00, "min4_lane3");
      release_out(1, 0, 0, 0);

      // NaN / signed zero / infinity under max
      open_win(0, 3);
      bt = '{mk(16'h7E00, 16'h7E00, 16'h7C00, 16'h0000),
             mk(16'h8000, 16'h7E00, 16'hFC00, 16'h8000),
             mk(16'h0000, 16'h7E00, 16'h7BFF, 16'h0000)};
      send(bt, 0, 0);
      wait_out();
      lane_is(0, 16'h8000, "nan_zero_lane0");
      lane_is(1, 16'h7E00, "all_nan_lane1");
      lane_is(2, 16'h7C00, "inf_lane2");
      lane_is(3, 16'h0000, "zero_tie_lane3");
      release_out(0, 0, 0, 0);

      // Gaps, start poked mid-window (ignored), 5-cycle output stall
      open_win(0, 2);
      bt = '{mk(16'h4000, 16'h0, 16'h0, 16'h0), mk(16'h4200, 16'h0, 16'h0, 16'h0)};
      send(bt, 70, 1);
      wait_out();
      lane_is(0, 16'h4200, "gap_lane0");
      for (int s = 0; s < 5; s++) begin
         bus.in_valid = 1'b1; bus.in_data = '1;
         tick();
      end
      bus.in_valid = 1'b0;
      lane_is(0, 16'h4200, "stall_hold_lane0");
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);

      // Back-to-back: start on handshake with win_len 0
      release_out(0, 1, 0, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(16'hFE01, 16'h8000, 16'h7C01, 16'h1234);
      @(negedge clk);
      chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("b2b_out_valid", {63'd0, bus.out_valid}, 64'd1);
      lane_is(0, 16'hFE01, "pass_nan_lane0");
      lane_is(1, 16'h8000, "pass_negzero_lane1");
      release_out(0, 0, 0, 0);

      // Reset mid-window
      open_win(0, 4);
      bt = '{mk(16'h5000, 16'h5000, 16'h5000, 16'h5000),
             mk(16'h5100, 16'h5100, 16'h5100, 16'h5100)};
      send(bt, 0, 0);
      rst = 1'b0;
      tick(); tick();
      chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("midrst_out_data", bus.out_data, 64'd0);
      chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
      rst = 1'b1;
      tick();
      open_win(0, 2);
      bt = '{mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
             mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00)};
      send(bt, 0, 0);
      wait_out();
      chk("post_rst_window", bus.out_data, 64'h3C003C003C003C00);
      release_out(0, 0, 0, 0);

      // Randomized windows
      chained = 0; nmd = 0; nwl = 0;
      for (int w = 0; w < 40; w++) begin
         md = chained ? nmd : 1'($urandom);
         wl = chained ? nwl : $urandom_range(0, 12);
         if (!chained) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            open_win(md, wl);
         end
         eff = (wl == 0) ? 1 : wl;
         bt.delete();
         for (int k = 0; k < eff; k++)
            bt.push_back(mk(rfp(), rfp(), rfp(), rfp()));
         send(bt, $urandom_range(0, 50), $urandom_range(0, 3) == 0);
         wait_out();
         chain = (w < 39) ? 1'($urandom) : 1'b0;
         nmd   = 1'($urandom);
         nwl   = $urandom_range(0, 12);
         release_out($urandom_range(0, 4), chain, nmd, nwl);
         chained = chain;
      end
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
